// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: requester-side controller for the 64-bit iterative divider.
// Accepts M-extension DIV/DIVU/REM/REMU (and W variants) from issue. It resolves
// divide-by-zero and signed overflow locally and hands every other op to the
// divider. The result is held until writeback accepts it.
module div_issue_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_in_valid,
  output logic [63:0]      div_a,
  output logic [63:0]      div_b,
  output logic             div_signed,
  output logic             div_flush,
  input  logic             div_result_valid,
  input  logic [63:0]      div_quotient,
  input  logic [63:0]      div_remainder
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;
  localparam logic [XLEN-1:0] MIN_NEG_D = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MIN_NEG_W = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Per-op registers; they feed the divider directly and must stay stable
  // for the whole divide because the divider's sign fixup is combinational.
  logic            rem_q;
  logic            word_q;
  logic            signed_q;
  logic [XLEN-1:0] pa_q;
  logic [XLEN-1:0] pb_q;

  logic [XLEN-1:0] out_data_d;

  logic            accept_c;
  logic            in_signed_c;
  logic            in_rem_c;
  logic [XLEN-1:0] pa_c;
  logic [XLEN-1:0] pb_c;
  logic            div_zero_c;
  logic            overflow_c;
  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic [XLEN-1:0] div_sel_c;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-WLEN){1'b0}}, x[WLEN-1:0]};
  endfunction

  // W results are always the sign-extension of the low word, even for DIVUW/REMUW.
  function automatic logic [XLEN-1:0] shape(input logic [XLEN-1:0] x, input logic word);
    return word ? sext_word(x) : x;
  endfunction

  assign in_signed_c = ~in_op[0];
  assign in_rem_c    = in_op[1];
  assign accept_c    = (state_q == IDLE) && in_valid && !flush;

  // Operand preparation: W ops extend the low word according to signedness.
  always_comb begin
    pa_c = in_a;
    pb_c = in_b;
    if (in_word) begin
      if (in_signed_c) begin
        pa_c = sext_word(in_a);
        pb_c = sext_word(in_b);
      end else begin
        pa_c = zext_word(in_a);
        pb_c = zext_word(in_b);
      end
    end
  end

  // Local resolution of divide-by-zero and signed overflow.
  always_comb begin
    div_zero_c    = (pb_c == '0);
    overflow_c    = in_signed_c && (pb_c == '1) &&
                    (pa_c == (in_word ? MIN_NEG_W : MIN_NEG_D));
    special_c     = div_zero_c || overflow_c;
    special_res_c = '0;
    if (div_zero_c) begin
      special_res_c = in_rem_c ? pa_c : '1;
    end else if (overflow_c) begin
      special_res_c = in_rem_c ? '0 : pa_c;
    end
  end

  assign div_sel_c = rem_q ? div_remainder : div_quotient;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and result selection; flush overrides every other transition.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (special_c) begin
            state_d    = DONE;
            out_data_d = shape(special_res_c, in_word);
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (div_result_valid) begin
          state_d    = DONE;
          out_data_d = shape(div_sel_c, word_q);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Datapath registers: op context captured at accept, result captured on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_tag  <= '0;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      pa_q     <= '0;
      pb_q     <= '0;
    end else begin
      out_data <= out_data_d;
      if (accept_c) begin
        out_tag  <= in_tag;
        rem_q    <= in_rem_c;
        word_q   <= in_word;
        signed_q <= in_signed_c;
        pa_q     <= pa_c;
        pb_q     <= pb_c;
      end
    end
  end

  // Handshake and divider interface, decoded from state and the op registers.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign div_in_valid = (state_q == ISSUE);
  assign div_a        = pa_q;
  assign div_b        = pb_q;
  assign div_signed   = signed_q;
  assign div_flush    = flush;

endmodule
